// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the program counter, strobes the instruction memory load,
// and presents fetched bytes to decode through a valid/ready instruction register.
module fetch_sequencer #(
    parameter int unsigned PC_W     = 8,
    parameter int unsigned INSTR_W  = 8,
    parameter int unsigned PROG_LEN = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [INSTR_W-1:0] instr_code,
    output logic [PC_W-1:0]    pc,
    output logic               imem_reset,
    output logic [INSTR_W-1:0] ir,
    output logic               ir_valid,
    input  logic               ir_ready,
    input  logic               branch_taken,
    input  logic [PC_W-1:0]    branch_target,
    input  logic               halt,
    output logic               running,
    output logic               err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_HALTED
    } state_t;

    localparam logic [PC_W-1:0] LAST_PC = PC_W'(PROG_LEN - 1);
    // One extra bit so a program filling the whole address space still compares correctly.
    localparam logic [PC_W:0]   LEN_EXT = (PC_W + 1)'(PROG_LEN);

    state_t          state;
    logic            ld_c;
    logic            target_ok_c;
    logic [PC_W-1:0] pc_seq_c;

    // Load when the register is empty or its content is being consumed this cycle.
    assign ld_c        = !ir_valid || ir_ready;
    assign target_ok_c = ({1'b0, branch_target} < LEN_EXT);
    assign pc_seq_c    = (pc == LAST_PC) ? '0 : pc + PC_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            pc         <= '0;
            ir         <= '0;
            ir_valid   <= 1'b0;
            running    <= 1'b0;
            err        <= 1'b0;
            imem_reset <= 1'b1;
        end else begin
            imem_reset <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state   <= S_FETCH;
                        running <= 1'b1;
                    end
                end
                S_FETCH: begin
                    // Halt outranks branch; branch outranks the normal load.
                    if (halt) begin
                        if (!ir_valid || ir_ready) begin
                            ir_valid <= 1'b0;
                            state    <= S_HALTED;
                            running  <= 1'b0;
                        end else begin
                            state <= S_DRAIN;
                        end
                    end else if (branch_taken) begin
                        ir_valid <= 1'b0;
                        if (target_ok_c) begin
                            pc <= branch_target;
                        end else begin
                            pc  <= '0;
                            err <= 1'b1;
                        end
                    end else if (ld_c) begin
                        ir       <= instr_code;
                        ir_valid <= 1'b1;
                        pc       <= pc_seq_c;
                    end
                end
                S_DRAIN: begin
                    if (ir_ready) begin
                        ir_valid <= 1'b0;
                        state    <= S_HALTED;
                        running  <= 1'b0;
                    end
                end
                S_HALTED: begin
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios plus randomized traffic against a behavioural model.
module tb_fetch_sequencer;

    localparam int PC_W     = 8;
    localparam int INSTR_W  = 8;
    localparam int PROG_LEN = 6;

    localparam int M_IDLE   = 0;
    localparam int M_FETCH  = 1;
    localparam int M_DRAIN  = 2;
    localparam int M_HALTED = 3;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic [INSTR_W-1:0] instr_code;
    logic [PC_W-1:0]    pc;
    logic               imem_reset;
    logic [INSTR_W-1:0] ir;
    logic               ir_valid;
    logic               ir_ready;
    logic               branch_taken;
    logic [PC_W-1:0]    branch_target;
    logic               halt;
    logic               running;
    logic               err;

    logic [INSTR_W-1:0] mem [PROG_LEN];

    int checks   = 0;
    int failures = 0;

    // Behavioural model state
    int                 m_state;
    int                 m_pc;
    logic [INSTR_W-1:0] m_ir;
    logic               m_v;
    logic               m_err;
    logic               m_imem;

    fetch_sequencer #(
        .PC_W    (PC_W),
        .INSTR_W (INSTR_W),
        .PROG_LEN(PROG_LEN)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .instr_code   (instr_code),
        .pc           (pc),
        .imem_reset   (imem_reset),
        .ir           (ir),
        .ir_valid     (ir_valid),
        .ir_ready     (ir_ready),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .halt         (halt),
        .running      (running),
        .err          (err)
    );

    always #5 clk = ~clk;

    // Combinational instruction memory
    always_comb begin
        instr_code = '0;
        for (int i = 0; i < PROG_LEN; i++) begin
            if (pc == PC_W'(i)) instr_code = mem[i];
        end
    end

    task automatic model_edge();
        if (reset) begin
            m_state = M_IDLE;
            m_pc    = 0;
            m_ir    = '0;
            m_v     = 1'b0;
            m_err   = 1'b0;
            m_imem  = 1'b1;
        end else begin
            m_imem = 1'b0;
            if (m_state == M_IDLE) begin
                if (start) m_state = M_FETCH;
            end else if (m_state == M_FETCH) begin
                if (halt) begin
                    if (!m_v || ir_ready) begin
                        m_v     = 1'b0;
                        m_state = M_HALTED;
                    end else begin
                        m_state = M_DRAIN;
                    end
                end else if (branch_taken) begin
                    m_v = 1'b0;
                    if (int'(branch_target) < PROG_LEN) begin
                        m_pc = int'(branch_target);
                    end else begin
                        m_pc  = 0;
                        m_err = 1'b1;
                    end
                end else if (!m_v || ir_ready) begin
                    m_ir = mem[m_pc];
                    m_v  = 1'b1;
                    m_pc = (m_pc + 1) % PROG_LEN;
                end
            end else if (m_state == M_DRAIN) begin
                if (ir_ready) begin
                    m_v     = 1'b0;
                    m_state = M_HALTED;
                end
            end
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic restart();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        checks++;
        if ({pc, ir, ir_valid, running, err, imem_reset} !== {8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL reset_values got pc=%h ir=%h v=%b run=%b err=%b imem=%b exp 00 00 0 0 0 1",
                     pc, ir, ir_valid, running, err, imem_reset);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (imem_reset !== 1'b0) begin
            failures++;
            $display("FAIL imem_reset_fall got=%b exp=0", imem_reset);
        end
        checks++;
        if (pc !== 8'h00 || ir_valid !== 1'b0 || running !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset got pc=%h v=%b run=%b exp pc=00 v=0 run=0", pc, ir_valid, running);
        end
        tick();
        checks++;
        if (imem_reset !== 1'b0 || ir_valid !== 1'b0) begin
            failures++;
            $display("FAIL idle_hold got imem=%b v=%b exp 0 0", imem_reset, ir_valid);
        end
    endtask

    task automatic test_stream();
        logic [PC_W-1:0] exp_pc [7];
        exp_pc = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd0, 8'd1};
        ir_ready = 1'b1;
        start    = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (running !== 1'b1 || ir_valid !== 1'b0 || pc !== 8'h00) begin
            failures++;
            $display("FAIL start_entry got run=%b v=%b pc=%h exp 1 0 00", running, ir_valid, pc);
        end
        for (int k = 0; k < 7; k++) begin
            tick();
            checks++;
            if (ir !== mem[k % PROG_LEN] || ir_valid !== 1'b1 || pc !== exp_pc[k]) begin
                failures++;
                $display("FAIL stream_%0d got ir=%h v=%b pc=%h exp ir=%h v=1 pc=%h",
                         k, ir, ir_valid, pc, mem[k % PROG_LEN], exp_pc[k]);
            end
        end
    endtask

    task automatic test_backpressure();
        restart();
        ir_ready = 1'b1;
        repeat (3) tick();
        ir_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if (ir !== mem[2] || ir_valid !== 1'b1 || pc !== 8'd3) begin
                failures++;
                $display("FAIL stall_hold_%0d got ir=%h v=%b pc=%h exp ir=%h v=1 pc=03", k, ir, ir_valid, pc, mem[2]);
            end
        end
        ir_ready = 1'b1;
        tick();
        checks++;
        if (ir !== mem[3] || ir_valid !== 1'b1 || pc !== 8'd4) begin
            failures++;
            $display("FAIL stall_release got ir=%h v=%b pc=%h exp ir=%h v=1 pc=04", ir, ir_valid, pc, mem[3]);
        end
    endtask

    task automatic test_branch();
        restart();
        ir_ready = 1'b1;
        repeat (2) tick();
        branch_taken  = 1'b1;
        branch_target = 8'd4;
        tick();
        branch_taken = 1'b0;
        checks++;
        if (ir_valid !== 1'b0 || pc !== 8'd4) begin
            failures++;
            $display("FAIL branch_flush got v=%b pc=%h exp v=0 pc=04", ir_valid, pc);
        end
        tick();
        checks++;
        if (ir !== mem[4] || ir_valid !== 1'b1 || pc !== 8'd5 || err !== 1'b0) begin
            failures++;
            $display("FAIL branch_target got ir=%h v=%b pc=%h err=%b exp ir=%h v=1 pc=05 err=0",
                     ir, ir_valid, pc, err, mem[4]);
        end
        branch_taken  = 1'b1;
        branch_target = 8'd7;
        tick();
        branch_taken = 1'b0;
        checks++;
        if (pc !== 8'd0 || err !== 1'b1 || ir_valid !== 1'b0) begin
            failures++;
            $display("FAIL branch_oob got pc=%h err=%b v=%b exp pc=00 err=1 v=0", pc, err, ir_valid);
        end
        repeat (5) begin
            ir_ready = 1'($urandom_range(0, 1));
            tick();
        end
        checks++;
        if (err !== 1'b1) begin
            failures++;
            $display("FAIL err_sticky got=%b exp=1", err);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL err_clear got=%b exp=0", err);
        end
    endtask

    task automatic test_halt_branch();
        restart();
        ir_ready = 1'b1;
        repeat (3) tick();
        halt          = 1'b1;
        branch_taken  = 1'b1;
        branch_target = 8'd1;
        tick();
        halt         = 1'b0;
        branch_taken = 1'b0;
        checks++;
        if (pc !== 8'd3 || ir_valid !== 1'b0 || running !== 1'b0) begin
            failures++;
            $display("FAIL halt_over_branch got pc=%h v=%b run=%b exp pc=03 v=0 run=0", pc, ir_valid, running);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        checks++;
        if (pc !== 8'd3 || ir_valid !== 1'b0 || running !== 1'b0) begin
            failures++;
            $display("FAIL halted_ignores_start got pc=%h v=%b run=%b exp pc=03 v=0 run=0", pc, ir_valid, running);
        end
    endtask

    task automatic test_halt_stall();
        restart();
        ir_ready = 1'b1;
        repeat (2) tick();
        ir_ready = 1'b0;
        halt     = 1'b1;
        tick();
        halt = 1'b0;
        checks++;
        if (running !== 1'b1 || ir_valid !== 1'b1 || ir !== mem[1] || pc !== 8'd2) begin
            failures++;
            $display("FAIL drain_entry got run=%b v=%b ir=%h pc=%h exp 1 1 %h 02", running, ir_valid, ir, pc, mem[1]);
        end
        branch_taken  = 1'b1;
        branch_target = 8'd0;
        tick();
        branch_taken = 1'b0;
        checks++;
        if (running !== 1'b1 || ir_valid !== 1'b1 || ir !== mem[1] || pc !== 8'd2) begin
            failures++;
            $display("FAIL drain_hold got run=%b v=%b ir=%h pc=%h exp 1 1 %h 02", running, ir_valid, ir, pc, mem[1]);
        end
        ir_ready = 1'b1;
        tick();
        ir_ready = 1'b0;
        checks++;
        if (ir_valid !== 1'b0 || running !== 1'b0 || pc !== 8'd2) begin
            failures++;
            $display("FAIL drain_done got v=%b run=%b pc=%h exp 0 0 02", ir_valid, running, pc);
        end
    endtask

    task automatic test_reset_mid();
        restart();
        ir_ready = 1'b1;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        checks++;
        if ({pc, ir, ir_valid, running, err, imem_reset} !== {8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL reset_mid got pc=%h ir=%h v=%b run=%b err=%b imem=%b exp 00 00 0 0 0 1",
                     pc, ir, ir_valid, running, err, imem_reset);
        end
        reset = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        checks++;
        if (ir !== mem[0] || ir_valid !== 1'b1 || pc !== 8'd1) begin
            failures++;
            $display("FAIL restart_first got ir=%h v=%b pc=%h exp ir=%h v=1 pc=01", ir, ir_valid, pc, mem[0]);
        end
    endtask

    task automatic test_random();
        logic m_run;
        for (int n = 0; n < 600; n++) begin
            reset         = ($urandom_range(0, 39) == 0);
            start         = ($urandom_range(0, 3) == 0);
            ir_ready      = ($urandom_range(0, 2) != 0);
            branch_taken  = ($urandom_range(0, 7) == 0);
            branch_target = PC_W'($urandom_range(0, 9));
            halt          = ($urandom_range(0, 29) == 0);
            tick();
            m_run = (m_state == M_FETCH) || (m_state == M_DRAIN);
            checks++;
            if (pc !== PC_W'(m_pc) || ir_valid !== m_v || (m_v && ir !== m_ir) ||
                running !== m_run || err !== m_err || imem_reset !== m_imem) begin
                failures++;
                $display("FAIL random_%0d got pc=%h v=%b ir=%h run=%b err=%b imem=%b exp pc=%h v=%b ir=%h run=%b err=%b imem=%b",
                         n, pc, ir_valid, ir, running, err, imem_reset,
                         PC_W'(m_pc), m_v, m_ir, m_run, m_err, m_imem);
            end
        end
        reset = 1'b0;
        start = 1'b0;
        halt  = 1'b0;
        branch_taken = 1'b0;
    endtask

    initial begin
        logic [7:0] base;
        base = 8'($urandom);
        for (int i = 0; i < PROG_LEN; i++) mem[i] = base + 8'(i * 37);
        reset         = 1'b1;
        start         = 1'b0;
        ir_ready      = 1'b0;
        branch_taken  = 1'b0;
        branch_target = '0;
        halt          = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_branch();
        test_halt_branch();
        test_halt_stall();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
